// File: rtl/scroll_bg_gu.sv
// Scrolling background raster unit: copies an H_RES x V_RES window of a wider image ROM.
// Define SCROLL_BG_PINGPONG_EN to bounce the scroll offset instead of wrapping it.
module scroll_bg_gu #(
  parameter int H_RES       = 320,
  parameter int V_RES       = 240,
  parameter int IMG_W       = 640,
  parameter int SCROLL_MIN  = 47,
  parameter int SCROLL_MAX  = 91,
  parameter int SCROLL_STEP = 2,
  parameter int COLOUR_W    = 3,
  parameter int ROM_LAT     = 1,
  localparam int X_W    = $clog2(H_RES),
  localparam int Y_W    = $clog2(V_RES),
  localparam int ADDR_W = $clog2(IMG_W * V_RES),
  localparam int OFF_W  = $clog2(IMG_W)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                frame,
  input  logic                plot,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                writeEn,
  output logic                busy,
  output logic                done
);

  localparam int LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
  localparam logic [LW-1:0]  L_LAST = LW'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [OFF_W-1:0] off_r, off_lat;
  logic [LW-1:0]    lat_q;
  logic             last_x, last_px, drain_end;

  assign last_x    = (x_q == X_LAST);
  assign last_px   = last_x && (y_q == Y_LAST);
  assign drain_end = (lat_q == L_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (plot) state_d = S_DRAW;
      S_DRAW:  if (last_px) state_d = S_DRAIN;
      S_DRAIN: if (drain_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q     <= '0;
      y_q     <= '0;
      off_lat <= '0;
      lat_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (plot) begin
            off_lat <= off_r;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        S_DRAW: begin
          lat_q <= '0;
          if (last_x) begin
            x_q <= '0;
            if (!last_px) y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        S_DRAIN: lat_q <= lat_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Offset arithmetic one bit wider so the upper-limit test cannot overflow
  logic [OFF_W:0]   up_sum;
  logic [OFF_W-1:0] off_nxt;
  logic             over, under;

  assign up_sum = {1'b0, off_r} + (OFF_W+1)'(SCROLL_STEP);
  assign over   = up_sum > (OFF_W+1)'(SCROLL_MAX);
  assign under  = {1'b0, off_r} < (OFF_W+1)'(SCROLL_MIN + SCROLL_STEP);

`ifdef SCROLL_BG_PINGPONG_EN
  logic up_q, up_nxt;

  always_comb begin
    off_nxt = up_sum[OFF_W-1:0];
    up_nxt  = up_q;
    if (up_q) begin
      if (over) begin
        up_nxt  = 1'b0;
        off_nxt = off_r - OFF_W'(SCROLL_STEP);
      end
    end else if (under) begin
      up_nxt = 1'b1;
    end else begin
      off_nxt = off_r - OFF_W'(SCROLL_STEP);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      off_r <= OFF_W'(SCROLL_MIN);
      up_q  <= 1'b1;
    end else if (frame) begin
      off_r <= off_nxt;
      up_q  <= up_nxt;
    end
  end
`else
  logic unused_under;
  assign unused_under = under;

  always_comb begin
    off_nxt = over ? OFF_W'(SCROLL_MIN) : up_sum[OFF_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    off_r <= OFF_W'(SCROLL_MIN);
    else if (frame) off_r <= off_nxt;
  end
`endif

  // x/y ride alongside the ROM read so colour and coordinates stay paired
  logic [ROM_LAT-1:0]          vld_q;
  logic [ROM_LAT-1:0][X_W-1:0] xp_q;
  logic [ROM_LAT-1:0][Y_W-1:0] yp_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      xp_q  <= '0;
      yp_q  <= '0;
    end else begin
      vld_q[0] <= (state_q == S_DRAW);
      xp_q[0]  <= x_q;
      yp_q[0]  <= y_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        xp_q[i]  <= xp_q[i-1];
        yp_q[i]  <= yp_q[i-1];
      end
    end
  end

  logic [ADDR_W-1:0] addr_c;

  assign addr_c = ADDR_W'(off_lat) + ADDR_W'(x_q)
                + ADDR_W'(y_q) * ADDR_W'(IMG_W);

  assign rom_addr   = (state_q == S_DRAW) ? addr_c : '0;
  assign writeEn    = vld_q[ROM_LAT-1];
  assign x_out      = writeEn ? xp_q[ROM_LAT-1] : '0;
  assign y_out      = writeEn ? yp_q[ROM_LAT-1] : '0;
  assign colour_out = writeEn ? rom_data : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_scroll_bg_gu.sv
// Bench for scroll_bg_gu: two instances (ROM latency 1 and 3) share stimulus,
// each with its own ROM model and scoreboard.
module tb_scroll_bg_gu;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int IW = 16;
  localparam int MN = 1;
  localparam int MX = 5;
  localparam int ST = 2;
  localparam int CW = 3;
  localparam int N  = H * V;
  localparam int AW = $clog2(IW * V);
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic frame = 1'b0;
  logic plot = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] ra0, ra1;
  logic [CW-1:0] rd0, rd1, co0, co1;
  logic [XW-1:0] xo0, xo1;
  logic [YW-1:0] yo0, yo1;
  logic          we0, we1, bz0, bz1, dn0, dn1;

  scroll_bg_gu #(
    .H_RES(H), .V_RES(V), .IMG_W(IW), .SCROLL_MIN(MN), .SCROLL_MAX(MX),
    .SCROLL_STEP(ST), .COLOUR_W(CW), .ROM_LAT(1)
  ) u0 (
    .clk(clk), .resetn(resetn), .frame(frame), .plot(plot),
    .rom_addr(ra0), .rom_data(rd0), .x_out(xo0), .y_out(yo0),
    .colour_out(co0), .writeEn(we0), .busy(bz0), .done(dn0)
  );

  scroll_bg_gu #(
    .H_RES(H), .V_RES(V), .IMG_W(IW), .SCROLL_MIN(MN), .SCROLL_MAX(MX),
    .SCROLL_STEP(ST), .COLOUR_W(CW), .ROM_LAT(3)
  ) u1 (
    .clk(clk), .resetn(resetn), .frame(frame), .plot(plot),
    .rom_addr(ra1), .rom_data(rd1), .x_out(xo1), .y_out(yo1),
    .colour_out(co1), .writeEn(we1), .busy(bz1), .done(dn1)
  );

  // ROM models: data = addr[2:0]; the delayed address is kept for checking
  logic [AW-1:0] rq0 [1];
  logic [AW-1:0] rq1 [3];

  always @(posedge clk) begin
    rq0[0] <= ra0;
    rq1[0] <= ra1;
    rq1[1] <= rq1[0];
    rq1[2] <= rq1[1];
  end

  assign rd0 = rq0[0][2:0];
  assign rd1 = rq1[2][2:0];

  typedef struct {
    int x;
    int y;
    int a;
    int c;
  } px_t;

  px_t pq [2][$];
  int  dq [2][$];
  int  blo [2] = '{0, 0};
  int  bhi [2] = '{-1, -1};
  int  lat [2] = '{1, 3};
  int  errs = 0;
  int  checks = 0;
  int  m_off = MN;
  bit  m_up = 1'b1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic we, input int xo, input int yo,
                     input int ra, input int co, input logic bz, input logic dn);
    px_t e;
    int  dc;
    check($sformatf("busy%0d", d), int'(bz), int'(cyc >= blo[d] && cyc <= bhi[d]));
    if (we) begin
      if (pq[d].size() == 0) begin
        check($sformatf("unexpected_wen%0d", d), 1, 0);
      end else begin
        e = pq[d].pop_front();
        check($sformatf("wen_cycle%0d", d), cyc, e.c);
        check($sformatf("x%0d", d), xo, e.x);
        check($sformatf("y%0d", d), yo, e.y);
        check($sformatf("addr%0d", d), ra, e.a);
        check($sformatf("colour%0d", d), co, e.a % 8);
      end
    end else if (pq[d].size() > 0 && pq[d][0].c <= cyc) begin
      check($sformatf("missing_wen%0d", d), 0, 1);
      void'(pq[d].pop_front());
    end
    if (dn) begin
      if (dq[d].size() == 0) begin
        check($sformatf("unexpected_done%0d", d), 1, 0);
      end else begin
        dc = dq[d].pop_front();
        check($sformatf("done_cycle%0d", d), cyc, dc);
      end
    end else if (dq[d].size() > 0 && dq[d][0] <= cyc) begin
      check($sformatf("missing_done%0d", d), 0, 1);
      void'(dq[d].pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0, we0, int'(xo0), int'(yo0), int'(rq0[0]), int'(co0), bz0, dn0);
    mon(1, we1, int'(xo1), int'(yo1), int'(rq1[2]), int'(co1), bz1, dn1);
  end

  // Reference scroll rule
  function automatic void m_frame();
`ifdef SCROLL_BG_PINGPONG_EN
    if (m_up) begin
      if (m_off + ST > MX) begin
        m_up = 1'b0;
        m_off = m_off - ST;
      end else begin
        m_off = m_off + ST;
      end
    end else begin
      if (m_off < MN + ST) begin
        m_up = 1'b1;
        m_off = m_off + ST;
      end else begin
        m_off = m_off - ST;
      end
    end
`else
    m_off = (m_off + ST > MX) ? MN : m_off + ST;
`endif
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      pq[d].delete();
      dq[d].delete();
      bhi[d] = -1;
    end
    m_off = MN;
    m_up = 1'b1;
  endtask

  task automatic issue(input bit with_frame);
    px_t e;
    int  t;
    t = cyc;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) begin
        e.x = k % H;
        e.y = k / H;
        e.a = m_off + (k % H) + (k / H) * IW;
        e.c = t + 1 + lat[d] + k;
        pq[d].push_back(e);
      end
      dq[d].push_back(t + N + lat[d] + 1);
      blo[d] = t + 1;
      bhi[d] = t + N + lat[d] + 1;
    end
    plot = 1'b1;
    frame = with_frame;
    if (with_frame) m_frame();
    @(negedge clk);
    plot = 1'b0;
    frame = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    m_frame();
    @(negedge clk);
    frame = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pq[0].size() + pq[1].size() + dq[0].size() + dq[1].size()) > 0
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("drain_timeout", 1, 0);
      clear_model();
    end
    @(negedge clk);
  endtask

  task automatic rst_chk(input string tag);
    check({tag, "_addr0"}, int'(ra0), 0);
    check({tag, "_addr1"}, int'(ra1), 0);
    check({tag, "_wen"}, int'(we0) + int'(we1), 0);
    check({tag, "_done"}, int'(dn0) + int'(dn1), 0);
    check({tag, "_busy"}, int'(bz0) + int'(bz1), 0);
    check({tag, "_xy"}, int'(xo0) + int'(xo1) + int'(yo0) + int'(yo1), 0);
    check({tag, "_colour"}, int'(co0) + int'(co1), 0);
  endtask

  int tbl[$];

  initial begin
`ifdef SCROLL_BG_PINGPONG_EN
    tbl = '{3, 5, 3, 1, 3};
`else
    tbl = '{3, 5, 1, 3};
`endif
    repeat (2) @(negedge clk);
    rst_chk("reset");
    check("reset_off0", int'(u0.off_r), MN);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic draw at offset 1
    issue(1'b0);
    wait_idle();

    // Scroll mid-draw and an ignored plot while busy
    issue(1'b0);
    repeat (2) @(negedge clk);
    pulse_frame();
    plot = 1'b1;
    @(negedge clk);
    plot = 1'b0;
    wait_idle();
    issue(1'b0);
    wait_idle();

    // Scroll sequence from reset
    resetn = 1'b0;
    clear_model();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      pulse_frame();
      check($sformatf("scroll_seq%0d", i), int'(u0.off_r), tbl[i]);
      check($sformatf("scroll_seq_lat3_%0d", i), int'(u1.off_r), m_off);
    end

    // Asynchronous reset in the middle of a draw
    resetn = 1'b0;
    clear_model();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    issue(1'b0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1 rst_chk("midreset");
    clear_model();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    issue(1'b0);
    wait_idle();

    // Randomized frames, simultaneous frame+plot and mid-draw scrolls
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 3)) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        pulse_frame();
      end
      issue(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) pulse_frame();
      wait_idle();
    end
    check("final_off0", int'(u0.off_r), m_off);
    check("final_off1", int'(u1.off_r), m_off);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/scroll_bg_gu.md
# scroll_bg_gu

Parametrised scrolling-background graphics unit. On a `plot` request it rasters an `H_RES`×`V_RES` window out of a wider background image ROM, starting at a horizontal scroll offset. It streams aligned pixel/colour writes to the VGA adapter write port and reports `done`. The scroll offset advances on each `frame` pulse. The offset is latched at draw start, so scrolling never tears a frame in progress.

## Interface
- `H_RES`, 320, drawn window width in pixels
- `V_RES`, 240, drawn window height in pixels
- `IMG_W`, 640, stored image row pitch in pixels; `SCROLL_MAX + H_RES <= IMG_W` required
- `SCROLL_MIN`, 47, lowest scroll offset (reset value)
- `SCROLL_MAX`, 91, highest scroll offset
- `SCROLL_STEP`, 2, offset change per `frame` pulse
- `COLOUR_W`, 3, colour width
- `ROM_LAT`, 1, image ROM read latency in cycles, ≥1
- Derived: `X_W=$clog2(H_RES)`, `Y_W=$clog2(V_RES)`, `ADDR_W=$clog2(IMG_W*V_RES)`, `OFF_W=$clog2(IMG_W)`

Ports:
- `clk` in 1: single clock
- `resetn` in 1: asynchronous, active-low reset
- `frame` in 1: one-cycle pulse per video frame; advances the scroll offset
- `plot` in 1: draw request; accepted only in IDLE
- `rom_addr` out ADDR_W: image ROM address
- `rom_data` in COLOUR_W: ROM read data, valid `ROM_LAT` cycles after `rom_addr`
- `x_out` out X_W: pixel x
- `y_out` out Y_W: pixel y
- `colour_out` out COLOUR_W: pixel colour
- `writeEn` out 1: pixel write strobe
- `busy` out 1: high from accept through the `done` cycle
- `done` out 1: one-cycle completion pulse

## Operation
- FSM states: IDLE → DRAW → DRAIN → DONE → IDLE.
  - IDLE: when `plot`=1, latch `off_r` into `off_lat`, clear `x`/`y`, go to DRAW.
  - DRAW: issue one address per cycle at `rom_addr = off_lat + x + y*IMG_W`, zero-extended to ADDR_W.
  - DRAW advances `x`; at `x==H_RES-1`, `x` returns to 0 and `y` increments.
  - After issuing `(H_RES-1, V_RES-1)`, go to DRAIN.
  - DRAIN lasts `ROM_LAT` cycles.
  - DONE: `done`=1 for one cycle, then IDLE.
- Alignment: a `ROM_LAT`-deep shift register carries valid, x and y. `writeEn`, `x_out` and `y_out` are its tail; `colour_out = rom_data`. Pixel address and colour always match.
- `plot` is ignored outside IDLE. `plot` held high restarts a new draw immediately after DONE.
- Scroll register `off_r` updates on every `frame` pulse, independent of the FSM state. Draw uses `off_lat` only.
- `frame` and `plot` in the same IDLE cycle: `off_lat` takes the pre-update `off_r`.
- All counters are exact width; no wrap except the defined `x`/`y`/offset rules.

## Timing
- Reset (async assert, sync release):
  - state IDLE
  - `off_r=SCROLL_MIN`, direction up
  - `rom_addr`, `x_out`, `y_out`, `colour_out`: 0
  - `writeEn`, `busy`, `done`: 0
  - pipeline valid bits cleared
- Reset mid-draw aborts immediately. No further `writeEn`, no `done`.
- With `N = H_RES*V_RES` and `plot` accepted at cycle t:
  - first address at t+1
  - first `writeEn` at t+1+ROM_LAT
  - last `writeEn` at t+N+ROM_LAT
  - `done` at t+N+ROM_LAT+1
- `writeEn` is continuous, with exactly N strobes per draw. `busy` rises at t+1.

## Configuration
- `SCROLL_BG_PINGPONG_EN` defined: offset bounces between the limits.
  - Going up: if `off_r + STEP > MAX`, flip to down and `off_r -= STEP`; else `off_r += STEP`.
  - Going down: if `off_r < MIN + STEP`, flip to up and `off_r += STEP`; else `off_r -= STEP`.
- Undefined: wrap mode. If `off_r + STEP > MAX`, then `off_r = MIN`; else `off_r += STEP`.
- Default params sequence (wrap mode): 47, 49, …, 91, 47.

## Test plan
- Params H_RES=4, V_RES=2, IMG_W=16, MIN=1, MAX=5, STEP=2, ROM_LAT=1; ROM returns `addr[2:0]`.
  - Stimulus: `plot` pulse.
  - Required: 8 `writeEn` strobes, with (x,y) in raster order (0,0)…(3,1).
  - Required: addresses 1,2,3,4,17,18,19,20.
  - Required: `done` exactly 1 cycle after the last strobe.
- Wrap mode, same params:
  - Stimulus: 4 `frame` pulses.
  - Required: `off_r` = 3, 5, 1, 3.
- `SCROLL_BG_PINGPONG_EN`, same params:
  - Stimulus: 5 `frame` pulses.
  - Required: `off_r` = 3, 5, 3, 1, 3.
- Mid-draw scroll:
  - Stimulus: `frame` pulses during DRAW.
  - Required: all addresses use `off_lat`=1; the next draw uses 3.
- ROM_LAT=3:
  - Required: colour/x/y alignment holds.
  - Required: `done` at t+N+4.
  - Stimulus: a second `plot` while busy.
  - Required: it is ignored.
- Reset pulse mid-draw:
  - Required: all outputs 0 asynchronously; no `done`.
  - Required: the next `plot` draws from (0,0) with offset 1.
